hamming_decode_engine: RTL and testbench

- Hardware SECDED decoder stage. It sits downstream of the Hamming encoder (program 1) and consumes the 16-bit encoded words that stage produces.
- On req, it sweeps NUM_WORDS encoded words out of data memory, computes syndrome and overall parity, and corrects single-bit errors. It flags double-bit errors.
- It writes each 11-bit message plus a 2-bit status flag back to memory, then raises done.

---
 rtl/hamming_decode_engine.sv | 158 +++++++++++++++
 tb/tb_hamming_decode_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decode_engine.sv
// SECDED decoder: sweeps NUM_WORDS encoded 16-bit words from memory, corrects
// single-bit errors, flags double-bit errors and writes message + status back.
module hamming_decode_engine #(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic [7:0]    single_cnt,
  output logic [7:0]    double_cnt
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE
  } state_e;

  localparam logic [1:0] FLAG_OK     = 2'b00;
  localparam logic [1:0] FLAG_SINGLE = 2'b01;
  localparam logic [1:0] FLAG_DOUBLE = 2'b10;

  state_e      state_q, state_d;
  logic [6:0]  k_q, k_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic [10:0] data_q, data_d;
  logic [1:0]  flag_q, flag_d;
  logic [7:0]  single_q, single_d, double_q, double_d;

  // Syndrome / parity / correction on the captured word.
  logic [15:0] w, wc;
  logic [3:0]  syn;
  logic        par;
  logic [1:0]  dec_flag;
  logic [10:0] dec_data;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w        = {hi_q, lo_q};
    wc       = w;
    syn      = '0;
    dec_flag = FLAG_OK;
    for (int i = 1; i < 16; i++) begin
      if (w[i]) syn = syn ^ 4'(i);
    end
    par = ^w;
    if (par) begin
      dec_flag = FLAG_SINGLE;
      // syn==0 means the flipped bit was p0; the data bits are already good.
      if (syn != 4'd0) wc[syn] = ~wc[syn];
    end else if (syn != 4'd0) begin
      dec_flag = FLAG_DOUBLE;
    end
    dec_data = {wc[15:9], wc[7:5], wc[3]};
  end

  logic [AW-1:0] src_lo, dst_lo;
  logic          last_word;

  assign src_lo    = AW'(SRC_BASE + 2 * int'(k_q));
  assign dst_lo    = AW'(DST_BASE + 2 * int'(k_q));
  assign last_word = (k_q == 7'(NUM_WORDS - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    data_d    = data_q;
    flag_d    = flag_q;
    single_d  = single_q;
    double_d  = double_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (req) begin
          state_d  = RD_LO;
          k_d      = '0;
          single_d = '0;
          double_d = '0;
        end
      end
      RD_LO: begin
        mem_addr = src_lo;
        lo_d     = mem_rdata;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_addr = src_lo + AW'(1);
        hi_d     = mem_rdata;
        state_d  = DECODE;
      end
      DECODE: begin
        data_d = dec_data;
        flag_d = dec_flag;
        if (dec_flag == FLAG_SINGLE && single_q != 8'hFF) single_d = single_q + 8'd1;
        if (dec_flag == FLAG_DOUBLE && double_q != 8'hFF) double_d = double_q + 8'd1;
        state_d = WR_LO;
      end
      WR_LO: begin
        mem_addr  = dst_lo;
        mem_we    = 1'b1;
        mem_wdata = data_q[7:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_addr  = dst_lo + AW'(1);
        mem_we    = 1'b1;
        mem_wdata = {flag_q, 3'b000, data_q[10:8]};
        if (last_word) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 7'd1;
          state_d = RD_LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      data_q   <= '0;
      flag_q   <= '0;
      single_q <= '0;
      double_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      flag_q   <= flag_d;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

  assign single_cnt = single_q;
  assign double_cnt = double_q;

endmodule

// File: tb/tb_hamming_decode_engine.sv
// Scoreboard bench for hamming_decode_engine: expected memory writes are queued
// at stimulus time and a negedge monitor checks each write the DUT issues.
module tb_hamming_decode_engine;

  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int NW  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       done;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic       mem_we;
  logic [7:0] single_cnt, double_cnt;

  logic [7:0] mem [256];
  logic       load_en = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;

  int n_run  = 0;
  int n_fail = 0;

  logic [15:0] exp_q [$];

  hamming_decode_engine #(
    .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW), .AW(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)       mem[mem_addr] <= mem_wdata;
    else if (load_en) mem[load_addr] <= load_data;
  end

  // Directed vectors: message and injected flip mask per word.
  logic [10:0] msg  [NW] = '{11'h7FF, 11'h7FF, 11'h000, 11'h000, 11'h123, 11'h555,
                             11'h2AA, 11'h001, 11'h400, 11'h3C5, 11'h71E, 11'h0F0,
                             11'h6B9, 11'h234, 11'h7A1};
  logic [15:0] mask [NW] = '{16'h0000, 16'h1000, 16'h0001, 16'h0003, 16'h0000, 16'h0020,
                             16'h4008, 16'h0200, 16'h8000, 16'h0081, 16'h0000, 16'h0002,
                             16'h0014, 16'h0100, 16'h0C00};
  logic [7:0]  hand_lo [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
  logic [7:0]  hand_hi [4] = '{8'h07, 8'h47, 8'h40, 8'h80};

  task automatic check(input string name, input int act, input int req_v);
    n_run++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] w;
    w        = '0;
    w[3]     = m[0];
    w[7:5]   = m[3:1];
    w[15:9]  = m[10:4];
    for (int b = 0; b < 4; b++) begin
      for (int i = 1; i < 16; i++) begin
        if ((i & (1 << b)) != 0 && i != (1 << b)) w[1 << b] = w[1 << b] ^ w[i];
      end
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  // Expected output bytes: hand values for the first four words, model otherwise.
  task automatic expected_bytes(input int k, output logic [7:0] lo, output logic [7:0] hi);
    logic [15:0] w;
    logic [10:0] d;
    logic [1:0]  f;
    if (k < 4) begin
      lo = hand_lo[k];
      hi = hand_hi[k];
    end else begin
      w  = encode(msg[k]) ^ mask[k];
      f  = 2'($countones(mask[k]));
      d  = (f == 2'b10) ? extract(w) : msg[k];
      lo = d[7:0];
      hi = {f, 3'b000, d[10:8]};
    end
  endtask

  task automatic push_words(input int count);
    logic [7:0] lo, hi;
    for (int k = 0; k < count; k++) begin
      expected_bytes(k, lo, hi);
      exp_q.push_back({8'(DST + 2 * k), lo});
      exp_q.push_back({8'(DST + 2 * k + 1), hi});
    end
  endtask

  task automatic load_sources();
    logic [15:0] w;
    for (int k = 0; k < NW; k++) begin
      w = encode(msg[k]) ^ mask[k];
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 8'(SRC + 2 * k + b);
        load_data = (b == 0) ? w[7:0] : w[15:8];
      end
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Counts edges after the req-sampling edge until done; optional stray req pulse.
  task automatic wait_done(input int poke_at);
    int edges;
    edges = 0;
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
      req = (edges == poke_at);
    end
    req = 1'b0;
    check("done_latency", edges, 5 * NW);
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), int'(e[15:8]));
        check($sformatf("wr_data@%0h", e[15:8]), int'(mem_wdata), int'(e[7:0]));
      end
    end
  end

  int exp_single, exp_double;

  initial begin
    exp_single = 0;
    exp_double = 0;
    for (int k = 0; k < NW; k++) begin
      if ($countones(mask[k]) == 1) exp_single++;
      if ($countones(mask[k]) == 2) exp_double++;
    end

    #12;
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    check("rst_single", int'(single_cnt), 0);
    check("rst_double", int'(double_cnt), 0);
    @(negedge clk);
    reset = 1'b0;

    // Full run, with a stray req while busy.
    load_sources();
    push_words(NW);
    start_run();
    check("busy_not_done", int'(done), 0);
    wait_done(20);
    check("run1_single", int'(single_cnt), exp_single);
    check("run1_double", int'(double_cnt), exp_double);
    @(negedge clk);
    check("done_hold", int'(done), 1);
    check("done_addr", int'(mem_addr), 0);
    check("done_we", int'(mem_we), 0);
    check("sb_drained_run1", exp_queue_size(), 0);

    // Second run from DONE, interrupted by reset after word 1 has been written.
    push_words(2);
    start_run();
    check("done_drops", int'(done), 0);
    repeat (12) @(negedge clk);
    check("mid_single", int'(single_cnt), 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_we", int'(mem_we), 0);
    check("mid_rst_single", int'(single_cnt), 0);
    check("mid_rst_double", int'(double_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    check("sb_drained_partial", exp_queue_size(), 0);

    // Restart after reset: begins at k=0 and completes normally.
    push_words(NW);
    start_run();
    wait_done(0);
    check("run3_single", int'(single_cnt), exp_single);
    check("run3_double", int'(double_cnt), exp_double);
    @(negedge clk);
    check("sb_drained_run3", exp_queue_size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  function automatic int exp_queue_size();
    return exp_q.size();
  endfunction

endmodule
